// File: rtl/cpu_trace_monitor_if.sv
// Trace read port between cpu_trace_monitor (master) and its consumer (slave).
// Show-ahead valid/ready handshake that carries one classified trace record.
interface cpu_trace_monitor_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            rd_valid;
    logic            rd_ready;
    logic [1:0]      rd_kind;
    logic [XLEN-1:0] rd_pc;
    logic [XLEN-1:0] rd_ir;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] rd_mdr;

    modport master (
        output rd_valid, rd_kind, rd_pc, rd_ir, rd_wdata, rd_mdr,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_kind, rd_pc, rd_ir, rd_wdata, rd_mdr,
        output rd_ready
    );
endinterface

// File: rtl/cpu_trace_monitor.sv
// Samples CPU observation buses per step, classifies PC/IR changes and queues trace records.
// Optional halt-on-breakpoint (trig_en/trig_pc ports) is built when TRACE_PC_TRIGGER_EN is defined.
module cpu_trace_monitor #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CNT_W        = 16,
    parameter bit          RING_DEFAULT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en,
    input  logic [XLEN-1:0]         pc_in,
    input  logic [XLEN-1:0]         ir_in,
    input  logic [XLEN-1:0]         mdr_in,
    input  logic [XLEN-1:0]         wdata_in,
    input  logic                    clear,
    input  logic                    ring_mode,
`ifdef TRACE_PC_TRIGGER_EN
    input  logic                    trig_en,
    input  logic [XLEN-1:0]         trig_pc,
`endif
    cpu_trace_monitor_if.master     trace,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        step_cnt,
    output logic [CNT_W-1:0]        seq_cnt,
    output logic [CNT_W-1:0]        jump_cnt,
    output logic [CNT_W-1:0]        lost_cnt,
    output logic                    frozen
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_ARMED, ST_RUN, ST_FROZEN} state_t;
    typedef enum logic [1:0] {
        KIND_SEQ   = 2'b00,
        KIND_JMP   = 2'b01,
        KIND_IRC   = 2'b10,
        KIND_FIRST = 2'b11
    } kind_t;

    typedef struct packed {
        kind_t           kind;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] mdr;
    } rec_t;

    state_t           state, state_nxt;
    kind_t            kind;
    rec_t             mem [DEPTH];
    rec_t             head, last_q, new_rec;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [XLEN-1:0]  prev_pc, prev_ir, pc_plus4;
    logic             ring_q, flush, push, pop, full, overflow, wr_en, rd_adv, trig_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef TRACE_PC_TRIGGER_EN
    assign trig_hit = trig_en && (pc_in == trig_pc);
`else
    assign trig_hit = 1'b0;
`endif

    assign flush    = rst || clear;
    assign pc_plus4 = prev_pc + XLEN'(4);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign pop      = (count != '0) && trace.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO only overflows without one.
    assign overflow = push && full && !pop;
    assign wr_en    = push && (!overflow || ring_q);
    assign rd_adv   = pop || (overflow && ring_q);
    assign new_rec  = '{kind: kind, pc: pc_in, ir: ir_in, wdata: wdata_in, mdr: mdr_in};

    always_ff @(posedge clk) begin
        if (flush) state <= ST_ARMED;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        kind      = KIND_SEQ;
        if (!flush) begin
            case (state)
                ST_ARMED: begin
                    if (sample_en) begin
                        push      = 1'b1;
                        kind      = KIND_FIRST;
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sample_en) begin
                        if (pc_in != prev_pc) begin
                            push = 1'b1;
                            kind = (pc_in == pc_plus4) ? KIND_SEQ : KIND_JMP;
                        end else if (ir_in != prev_ir) begin
                            push = 1'b1;
                            kind = KIND_IRC;
                        end
                        if ((push && full && !pop && !ring_q) || trig_hit) state_nxt = ST_FROZEN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                               ring_q <= RING_DEFAULT;
        else if (!clear && state == ST_ARMED)  ring_q <= ring_mode;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= new_rec;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_q   <= '0;
            prev_pc  <= '0;
            prev_ir  <= '0;
            step_cnt <= '0;
            seq_cnt  <= '0;
            jump_cnt <= '0;
            lost_cnt <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_adv)      count <= count + 1'b1;
            else if (!wr_en && rd_adv) count <= count - 1'b1;
            if (pop) last_q <= head;
            if (sample_en && state != ST_FROZEN) begin
                prev_pc <= pc_in;
                prev_ir <= ir_in;
            end
            if (sample_en)                   step_cnt <= sat_inc(step_cnt);
            if (push && kind == KIND_SEQ)    seq_cnt  <= sat_inc(seq_cnt);
            if (push && kind == KIND_JMP)    jump_cnt <= sat_inc(jump_cnt);
            if (overflow)                    lost_cnt <= sat_inc(lost_cnt);
        end
    end

    // Empty FIFO keeps presenting the most recently consumed record.
    assign head           = (count != '0) ? mem[rd_ptr] : last_q;
    assign trace.rd_valid = (count != '0);
    assign trace.rd_kind  = head.kind;
    assign trace.rd_pc    = head.pc;
    assign trace.rd_ir    = head.ir;
    assign trace.rd_wdata = head.wdata;
    assign trace.rd_mdr   = head.mdr;
    assign level          = count;
    assign frozen         = (state == ST_FROZEN);
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Table-driven bench for cpu_trace_monitor with a record scoreboard for the trace FIFO.
// Trigger scenario is compiled in when TRACE_PC_TRIGGER_EN is defined.
module tb_cpu_trace_monitor;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] K_SEQ = 2'b00, K_JMP = 2'b01, K_IRC = 2'b10, K_FIRST = 2'b11;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] wd;
        logic [31:0] md;
    } rec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [1:0]  kind;
        bit          rec;
        int unsigned lvl;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   sample_en = 1'b0;
    logic [XLEN-1:0]        pc_in = '0, ir_in = '0, mdr_in = '0, wdata_in = '0;
    logic                   clear = 1'b0;
    logic                   ring_mode = 1'b1;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       step_cnt, seq_cnt, jump_cnt, lost_cnt;
    logic                   frozen;
`ifdef TRACE_PC_TRIGGER_EN
    logic                   trig_en = 1'b0;
    logic [XLEN-1:0]        trig_pc = '0;
`endif

    cpu_trace_monitor_if #(.XLEN(XLEN)) trace_bus ();

    cpu_trace_monitor #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .RING_DEFAULT(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en),
        .pc_in(pc_in), .ir_in(ir_in), .mdr_in(mdr_in), .wdata_in(wdata_in),
        .clear(clear), .ring_mode(ring_mode),
`ifdef TRACE_PC_TRIGGER_EN
        .trig_en(trig_en), .trig_pc(trig_pc),
`endif
        .trace(trace_bus),
        .level(level), .step_cnt(step_cnt), .seq_cnt(seq_cnt),
        .jump_cnt(jump_cnt), .lost_cnt(lost_cnt), .frozen(frozen)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    rec_t q[$];
    bit   m_ring = 1'b1;
    vec_t tbl [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: optionally sample, optionally consume the head (checked against the scoreboard).
    task automatic tick(input bit s, input logic [31:0] pc, input logic [31:0] ir,
                        input bit rdy, input bit rec, input logic [1:0] kind);
        rec_t r;
        r.kind = kind; r.pc = pc; r.ir = ir; r.wd = $urandom; r.md = $urandom;
        sample_en = s; pc_in = pc; ir_in = ir; wdata_in = r.wd; mdr_in = r.md;
        trace_bus.rd_ready = rdy;
        if (rdy) begin
            if (q.size() > 0) begin
                chk("rd_valid", trace_bus.rd_valid, 1);
                chk("rd_kind", trace_bus.rd_kind, q[0].kind);
                chk("rd_pc", trace_bus.rd_pc, q[0].pc);
                chk("rd_ir", trace_bus.rd_ir, q[0].ir);
                chk("rd_wdata", trace_bus.rd_wdata, q[0].wd);
                chk("rd_mdr", trace_bus.rd_mdr, q[0].md);
                void'(q.pop_front());
            end else begin
                chk("rd_valid_empty", trace_bus.rd_valid, 0);
            end
        end
        if (rec) begin
            if (q.size() == DEPTH) begin
                if (m_ring) begin
                    void'(q.pop_front());
                    q.push_back(r);
                end
            end else begin
                q.push_back(r);
            end
        end
        @(posedge clk); #1;
        sample_en = 1'b0;
        trace_bus.rd_ready = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3 * DEPTH && q.size() > 0; n++) tick(0, 0, 0, 1, 0, K_SEQ);
        chk("drain_level", level, 0);
        chk("drain_valid", trace_bus.rd_valid, 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        q.delete();
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 32'h0050_0093, K_FIRST, 1'b1, 1};
        tbl[1] = '{32'h0000_0004, 32'h00A0_0113, K_SEQ,   1'b1, 2};
        tbl[2] = '{32'h0000_0008, 32'h0020_81B3, K_SEQ,   1'b1, 3};
        tbl[3] = '{32'h0000_000C, 32'h0000_0013, K_SEQ,   1'b1, 4};
        tbl[4] = '{32'h0000_0040, 32'h0000_0063, K_JMP,   1'b1, 5};
        tbl[5] = '{32'h0000_0040, 32'h0010_0073, K_IRC,   1'b1, 6};
        tbl[6] = '{32'h0000_0040, 32'h0010_0073, K_SEQ,   1'b0, 6};

        trace_bus.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_level", level, 0);
        chk("rst_valid", trace_bus.rd_valid, 0);
        chk("rst_step", step_cnt, 0);
        chk("rst_seq", seq_cnt, 0);
        chk("rst_jump", jump_cnt, 0);
        chk("rst_lost", lost_cnt, 0);
        chk("rst_frozen", frozen, 0);
        chk("rst_rd_pc", trace_bus.rd_pc, 0);
        chk("rst_rd_kind", trace_bus.rd_kind, 0);

        for (int i = 0; i < 7; i++) begin
            tick(1, tbl[i].pc, tbl[i].ir, 0, tbl[i].rec, tbl[i].kind);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            if (i == 2) begin
                chk("first3_seq", seq_cnt, 2);
                chk("first3_jump", jump_cnt, 0);
                chk("first3_step", step_cnt, 3);
            end
        end
        chk("tbl_step", step_cnt, 7);
        chk("tbl_seq", seq_cnt, 3);
        chk("tbl_jump", jump_cnt, 1);
        drain();
        chk("hold_rd_pc", trace_bus.rd_pc, 32'h40);
        chk("hold_rd_kind", trace_bus.rd_kind, K_IRC);

        // Ring mode overflow: oldest four records are overwritten.
        ring_mode = 1'b1; m_ring = 1'b1;
        do_clear();
        chk("clr_level", level, 0);
        chk("clr_step", step_cnt, 0);
        chk("clr_seq", seq_cnt, 0);
        for (int i = 0; i < 20; i++)
            tick(1, 32'h100 + 32'(i) * 8, 32'h13, 0, 1, (i == 0) ? K_FIRST : K_JMP);
        chk("ring_level", level, 16);
        chk("ring_lost", lost_cnt, 4);
        chk("ring_head_pc", trace_bus.rd_pc, 32'h120);
        chk("ring_jump", jump_cnt, 19);
        chk("ring_frozen", frozen, 0);
        drain();

        // Stop mode overflow freezes capture; ring_mode toggled while running has no effect.
        ring_mode = 1'b0; m_ring = 1'b0;
        do_clear();
        for (int i = 0; i < 17; i++) begin
            tick(1, 32'h200 + 32'(i) * 8, 32'h13, 0, 1, (i == 0) ? K_FIRST : K_JMP);
            if (i == 0) ring_mode = 1'b1;
        end
        chk("stop_level", level, 16);
        chk("stop_lost", lost_cnt, 1);
        chk("stop_frozen", frozen, 1);
        tick(1, 32'h900, 32'h13, 0, 0, K_JMP);
        tick(1, 32'h904, 32'h17, 0, 0, K_SEQ);
        chk("frz_level", level, 16);
        chk("frz_lost", lost_cnt, 1);
        chk("frz_step", step_cnt, 19);
        chk("frz_head_pc", trace_bus.rd_pc, 32'h200);

        // Clear wins over a same-cycle sample.
        ring_mode = 1'b0;
        clear = 1'b1; sample_en = 1'b1; pc_in = 32'h500;
        @(posedge clk); #1;
        clear = 1'b0; sample_en = 1'b0;
        q.delete();
        chk("clr2_level", level, 0);
        chk("clr2_frozen", frozen, 0);
        chk("clr2_step", step_cnt, 0);
        chk("clr2_lost", lost_cnt, 0);
        chk("clr2_jump", jump_cnt, 0);
        chk("clr2_valid", trace_bus.rd_valid, 0);
        chk("clr2_rd_pc", trace_bus.rd_pc, 0);

        // Full FIFO with concurrent pop and push (stop mode), including PC wrap.
        for (int i = 0; i < 16; i++)
            tick(1, 32'hFFFF_FFC0 + 32'(i) * 4, 32'h13, 0, 1, (i == 0) ? K_FIRST : K_SEQ);
        chk("full_level", level, 16);
        chk("full_lost", lost_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 32'(i) * 4, 32'h13, 1, 1, K_SEQ);
            chk($sformatf("pp%0d_level", i), level, 16);
        end
        chk("pp_lost", lost_cnt, 0);
        chk("pp_frozen", frozen, 0);
        chk("pp_seq", seq_cnt, 18);
        drain();

`ifdef TRACE_PC_TRIGGER_EN
        ring_mode = 1'b1; m_ring = 1'b1;
        do_clear();
        trig_en = 1'b1; trig_pc = 32'h20;
        for (int i = 0; i <= 10; i++)
            tick(1, 32'(i) * 4, 32'h13, 0, (i <= 8), (i == 0) ? K_FIRST : K_SEQ);
        chk("trig_frozen", frozen, 1);
        chk("trig_level", level, 9);
        trig_en = 1'b0;
        drain();
        chk("trig_last_pc", trace_bus.rd_pc, 32'h20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
